// File: rtl/pellet_eater.sv
// Read-modify-write controller on map BRAM port A: reads the tile at a requested
// position, clears edible tiles, and keeps score / pellets-remaining bookkeeping.
module pellet_eater #(
   parameter int DATA_WIDTH   = 4,
   parameter int DATA_DEPTH   = 1023,
   parameter int MAP_COLS     = 28,
   parameter int MAP_ROWS     = 36,
   parameter int PELLET_TOTAL = 244,
   parameter int PELLET_PTS   = 10,
   parameter int POWER_PTS    = 50,
   localparam int AW = $clog2(DATA_DEPTH),
   localparam int CW = $clog2(MAP_COLS),
   localparam int RW = $clog2(MAP_ROWS),
   localparam int PW = $clog2(PELLET_TOTAL + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [CW-1:0]         tile_col,
   input  logic [RW-1:0]         tile_row,
   output logic [AW-1:0]         bram_addr,
   output logic                  bram_we,
   output logic [DATA_WIDTH-1:0] bram_din,
   input  logic [DATA_WIDTH-1:0] bram_dout,
   input  logic                  level_reload,
   output logic [15:0]           score,
   output logic [PW-1:0]         pellets_left,
   output logic                  pellet_eaten,
   output logic                  power_eaten,
   output logic                  level_clear
);

   typedef enum logic [1:0] {IDLE, READ, CHECK, WRITE} state_t;

   state_t        state;
   logic [AW-1:0] addr_calc;
   logic          in_range;
   logic          is_pellet;
   logic          is_power;
   logic [16:0]   score_sum;

   always_comb begin
      addr_calc = AW'(tile_row) * AW'(MAP_COLS) + AW'(tile_col);
      in_range  = (32'(tile_col) < MAP_COLS) && (32'(tile_row) < MAP_ROWS);
      is_pellet = (bram_dout == DATA_WIDTH'(2));
      is_power  = (bram_dout == DATA_WIDTH'(3));
      // One extra bit catches the carry so the score can clamp instead of wrapping.
      score_sum = {1'b0, score} + (is_power ? 17'(POWER_PTS) : 17'(PELLET_PTS));
   end

   assign req_ready   = (state == IDLE);
   assign level_clear = (pellets_left == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         bram_addr    <= '0;
         bram_we      <= 1'b0;
         bram_din     <= '0;
         score        <= '0;
         pellets_left <= PW'(PELLET_TOTAL);
         pellet_eaten <= 1'b0;
         power_eaten  <= 1'b0;
      end else begin
         bram_we      <= 1'b0;
         pellet_eaten <= 1'b0;
         power_eaten  <= 1'b0;
         if (level_reload) begin
            state        <= IDLE;
            pellets_left <= PW'(PELLET_TOTAL);
         end else begin
            case (state)
               IDLE: begin
                  // Out-of-range requests are consumed without touching the BRAM.
                  if (req_valid && in_range) begin
                     bram_addr <= addr_calc;
                     state     <= READ;
                  end
               end
               READ: state <= CHECK;
               CHECK: begin
                  if (is_pellet || is_power) begin
                     bram_we      <= 1'b1;
                     bram_din     <= '0;
                     score        <= score_sum[16] ? '1 : score_sum[15:0];
                     if (pellets_left != '0)
                        pellets_left <= pellets_left - PW'(1);
                     pellet_eaten <= is_pellet;
                     power_eaten  <= is_power;
                     state        <= WRITE;
                  end else begin
                     state <= IDLE;
                  end
               end
               WRITE:   state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pellet_eater.sv
// Bench for pellet_eater: BRAM stand-in, transaction-timeline reference model,
// per-cycle compare process and directed scenarios with literal expectations.
module tb_pellet_eater;

   localparam int COLS  = 28;
   localparam int ROWS  = 36;
   localparam int TOTAL = 244;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [4:0]  tile_col = '0;
   logic [5:0]  tile_row = '0;
   logic [9:0]  bram_addr;
   logic        bram_we;
   logic [3:0]  bram_din;
   logic [3:0]  bram_dout;
   logic        level_reload = 1'b0;
   logic [15:0] score;
   logic [7:0]  pellets_left;
   logic        pellet_eaten;
   logic        power_eaten;
   logic        level_clear;

   always #5 clk = ~clk;

   pellet_eater #(
      .DATA_WIDTH(4), .DATA_DEPTH(1023), .MAP_COLS(COLS), .MAP_ROWS(ROWS),
      .PELLET_TOTAL(TOTAL), .PELLET_PTS(10), .POWER_PTS(50)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .tile_col(tile_col), .tile_row(tile_row), .bram_addr(bram_addr),
      .bram_we(bram_we), .bram_din(bram_din), .bram_dout(bram_dout),
      .level_reload(level_reload), .score(score), .pellets_left(pellets_left),
      .pellet_eaten(pellet_eaten), .power_eaten(power_eaten), .level_clear(level_clear)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Map BRAM stand-in with a side write port used to load/refill tiles.
   logic [3:0] mem [0:1022];
   logic       tb_wr_en = 1'b0;
   logic [9:0] tb_wr_addr = '0;
   logic [3:0] tb_wr_data = '0;

   always @(posedge clk) begin
      if (bram_we) mem[bram_addr] <= bram_din;
      else if (tb_wr_en) mem[tb_wr_addr] <= tb_wr_data;
      bram_dout <= mem[bram_addr];
   end

   // Reference model: a request accepted in cycle c is ready again at c+3 or
   // c+4; an edible one shows its write/pulse/new counters in cycle c+3.
   int m_map [0:1023];
   int cyc = 0, ready_at = 0, eff_cyc = -1, eff_kind = 0, eff_addr = 0;
   int m_addr = 0, m_score = 0, m_left = TOTAL;

   always @(posedge clk or posedge rst) begin
      if (tb_wr_en) m_map[tb_wr_addr] = int'(tb_wr_data);
      if (rst) begin
         ready_at = 0; eff_cyc = -1; m_addr = 0; m_score = 0; m_left = TOTAL;
      end else begin
         if (eff_cyc == cyc) m_map[eff_addr] = 0;
         if (level_reload) begin
            ready_at = cyc + 1;
            if (eff_cyc > cyc) eff_cyc = -1;
            m_left = TOTAL;
         end else if (req_valid && cyc >= ready_at) begin
            if (int'(tile_col) < COLS && int'(tile_row) < ROWS) begin
               m_addr = int'(tile_row) * COLS + int'(tile_col);
               if (m_map[m_addr] == 2 || m_map[m_addr] == 3) begin
                  eff_cyc = cyc + 3; eff_kind = m_map[m_addr]; eff_addr = m_addr;
                  ready_at = cyc + 4;
               end else begin
                  ready_at = cyc + 3;
               end
            end
         end
         if (eff_cyc == cyc + 1) begin
            m_score = m_score + ((eff_kind == 3) ? 50 : 10);
            if (m_score > 65535) m_score = 65535;
            if (m_left > 0) m_left--;
         end
         cyc++;
      end
   end

   int we_cnt = 0, pel_cnt = 0, pow_cnt = 0, last_we_addr = -1;

   always @(negedge clk) begin
      if (!rst) begin
         chk("req_ready",    32'(req_ready),    32'(cyc >= ready_at));
         chk("bram_we",      32'(bram_we),      32'(eff_cyc == cyc));
         chk("bram_addr",    32'(bram_addr),    m_addr);
         chk("bram_din",     32'(bram_din),     32'(0));
         chk("pellet_eaten", 32'(pellet_eaten), 32'(eff_cyc == cyc && eff_kind == 2));
         chk("power_eaten",  32'(power_eaten),  32'(eff_cyc == cyc && eff_kind == 3));
         chk("score",        32'(score),        m_score);
         chk("pellets_left", 32'(pellets_left), m_left);
         chk("level_clear",  32'(level_clear),  32'(m_left == 0));
         if (bram_we) begin we_cnt++; last_we_addr = int'(bram_addr); end
         if (pellet_eaten) pel_cnt++;
         if (power_eaten) pow_cnt++;
      end
   end

   task automatic tick;
      @(posedge clk); #1;
   endtask

   task automatic wr_tile(input int a, input int code);
      @(negedge clk); #2;
      tb_wr_en = 1'b1; tb_wr_addr = 10'(a); tb_wr_data = 4'(code);
      @(posedge clk); #1;
      tb_wr_en = 1'b0;
   endtask

   // Cycles from handshake until req_ready is seen high again (capped at 20).
   task automatic do_req(input int col, input int row, output int lat);
      @(negedge clk); #2;
      req_valid = 1'b1; tile_col = 5'(col); tile_row = 6'(row);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
      while (!req_ready && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      int lat, w0, p0, q0;
      wr_tile(29, 2); wr_tile(85, 3); wr_tile(0, 1); wr_tile(58, 2);
      for (int a = 100; a < 100 + TOTAL; a++) wr_tile(a, 2);
      @(negedge clk); #2 rst = 1'b0;
      tick;
      chk("rst_ready", 32'(req_ready), 1);
      chk("rst_we", 32'(bram_we), 0);
      chk("rst_score", 32'(score), 0);
      chk("rst_left", 32'(pellets_left), 244);
      chk("rst_clear", 32'(level_clear), 0);

      // Pellet at (1,1)
      w0 = we_cnt; p0 = pel_cnt;
      do_req(1, 1, lat);
      chk("pellet_lat", lat, 4);
      chk("pellet_score", 32'(score), 10);
      chk("pellet_left", 32'(pellets_left), 243);
      chk("pellet_we_cycles", we_cnt - w0, 1);
      chk("pellet_pulses", pel_cnt - p0, 1);
      chk("pellet_we_addr", last_we_addr, 29);
      chk("pellet_cleared", 32'(mem[29]), 0);

      // Same tile again: now empty
      w0 = we_cnt;
      do_req(1, 1, lat);
      chk("again_lat", lat, 3);
      chk("again_score", 32'(score), 10);
      chk("again_we_cycles", we_cnt - w0, 0);

      // Power pellet at (1,3)
      w0 = we_cnt; q0 = pow_cnt;
      do_req(1, 3, lat);
      chk("power_lat", lat, 4);
      chk("power_score", 32'(score), 60);
      chk("power_left", 32'(pellets_left), 242);
      chk("power_pulses", pow_cnt - q0, 1);
      chk("power_we_cycles", we_cnt - w0, 1);
      chk("power_we_addr", last_we_addr, 85);

      // Wall, then out-of-range column and row
      w0 = we_cnt;
      do_req(0, 0, lat);
      chk("wall_lat", lat, 3);
      do_req(28, 35, lat);
      chk("oor_col_lat", lat, 1);
      do_req(0, 36, lat);
      chk("oor_row_lat", lat, 1);
      chk("oor_addr_kept", 32'(bram_addr), 0);
      chk("wall_oor_we_cycles", we_cnt - w0, 0);
      chk("wall_oor_score", 32'(score), 60);

      // level_reload during CHECK of the pellet at (2,2)
      w0 = we_cnt;
      @(negedge clk); #2;
      req_valid = 1'b1; tile_col = 5'd2; tile_row = 6'd2;
      tick; req_valid = 1'b0;
      tick; level_reload = 1'b1;
      tick; level_reload = 1'b0;
      chk("reload_ready", 32'(req_ready), 1);
      chk("reload_we", 32'(bram_we), 0);
      chk("reload_left", 32'(pellets_left), 244);
      chk("reload_score", 32'(score), 60);
      tick;
      chk("reload_we_cycles", we_cnt - w0, 0);
      chk("reload_tile_kept", 32'(mem[58]), 2);

      // rst during WRITE of the same pellet
      @(negedge clk); #2;
      req_valid = 1'b1; tile_col = 5'd2; tile_row = 6'd2;
      tick; req_valid = 1'b0;
      tick;
      tick;
      chk("write_we_high", 32'(bram_we), 1);
      chk("write_addr", 32'(bram_addr), 58);
      chk("write_left", 32'(pellets_left), 243);
      #1 rst = 1'b1;
      #1;
      chk("rst_write_we", 32'(bram_we), 0);
      chk("rst_write_score", 32'(score), 0);
      chk("rst_write_left", 32'(pellets_left), 244);
      @(negedge clk); #2 rst = 1'b0;
      tick;
      chk("rst_write_tile_kept", 32'(mem[58]), 2);

      // Eat every pellet of the level
      for (int a = 100; a < 100 + TOTAL; a++) begin
         do_req(a % COLS, a / COLS, lat);
         chk("bulk_lat", lat, 4);
         if (a == 100 + TOTAL - 2) begin
            chk("one_left", 32'(pellets_left), 1);
            chk("one_left_clear", 32'(level_clear), 0);
         end
      end
      chk("cleared_left", 32'(pellets_left), 0);
      chk("cleared_flag", 32'(level_clear), 1);
      chk("cleared_score", 32'(score), 2440);

      // Edible tile with nothing left to count
      w0 = we_cnt;
      do_req(2, 2, lat);
      chk("extra_lat", lat, 4);
      chk("extra_left", 32'(pellets_left), 0);
      chk("extra_score", 32'(score), 2450);
      chk("extra_we_cycles", we_cnt - w0, 1);
      chk("extra_flag", 32'(level_clear), 1);

      // Drive the score up to saturation by refilling address 100 = (16,3)
      for (int i = 0; i < 1261; i++) begin
         wr_tile(100, 3);
         do_req(16, 3, lat);
      end
      chk("sat_pre_score", 32'(score), 65500);
      for (int i = 0; i < 3; i++) begin
         wr_tile(100, 2);
         do_req(16, 3, lat);
      end
      chk("sat_65530", 32'(score), 65530);
      wr_tile(100, 2);
      do_req(16, 3, lat);
      chk("sat_pellet", 32'(score), 65535);
      wr_tile(100, 3);
      do_req(16, 3, lat);
      chk("sat_power", 32'(score), 65535);
      chk("sat_left", 32'(pellets_left), 0);

      tick;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
